// File: rtl/core_pkg.sv
// Shared core constants and types.
// The register file's optional write-to-read bypass is selected with the
// RF_BYPASS_EN macro; this package is the same in both builds.
package core_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_DATA_WIDTH = 32;

   typedef enum logic {
      RF_SCRUB_IDLE  = 1'b0,
      RF_SCRUB_CLEAR = 1'b1
   } rf_scrub_state_e;

endpackage

// File: rtl/rf_scrub_ctrl.sv
// Scrub sequencer for the register file.
// A clear request walks the counter over registers 1..NUM_WORDS-1, one per
// cycle. Register 0 is hardwired to zero, so it is never visited.
//
// state          | meaning
// ---------------+------------------------------------------------------
// RF_SCRUB_IDLE  | waiting for clear_i; counter parked at 1
// RF_SCRUB_CLEAR | zeroing register scrub_addr_o this cycle, then advance
module rf_scrub_ctrl
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear_i,
   output logic                  scrub_active_o,
   output logic [ADDR_WIDTH-1:0] scrub_addr_o,
   output logic                  scrub_we_o
);

   localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   rf_scrub_state_e       state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;

   // Scrub FSM and address counter; a clear request during CLEAR is ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RF_SCRUB_IDLE;
         cnt_q   <= CNT_ONE;
      end else begin
         case (state_q)
            RF_SCRUB_IDLE: begin
               if (clear_i) begin
                  state_q <= RF_SCRUB_CLEAR;
                  cnt_q   <= CNT_ONE;
               end
            end
            RF_SCRUB_CLEAR: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= RF_SCRUB_IDLE;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= RF_SCRUB_IDLE;
               cnt_q   <= CNT_ONE;
            end
         endcase
      end
   end

   assign scrub_active_o = (state_q == RF_SCRUB_CLEAR);
   assign scrub_we_o     = (state_q == RF_SCRUB_CLEAR);
   assign scrub_addr_o   = cnt_q;

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port integer register file with busy scoreboard and scrub.
// Register 0 reads as zero and is never written or reserved.
// Optional feature macro: RF_BYPASS_EN forwards same-cycle write data to
// matching read ports (highest write port wins); undefined, reads see only
// stored contents.
module multiport_register_file
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr_ip,
   output logic [NUM_READ*DATA_WIDTH-1:0]  rdata_op,
   output logic [NUM_READ-1:0]             rbusy_op,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr_ip,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_ip,
   input  logic [NUM_WRITE-1:0]            we_ip,
   input  logic                            reserve_ip,
   input  logic [ADDR_WIDTH-1:0]           reserve_addr_ip,
   input  logic                            clear_ip,
   output logic                            clear_busy_op
);

   localparam int NUM_WORDS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rf_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0] rf_d [NUM_WORDS];
   logic [NUM_WORDS-1:0]  busy_q;
   logic [NUM_WORDS-1:0]  busy_d;

   logic                  scrub_active;
   logic [ADDR_WIDTH-1:0] scrub_addr;
   logic                  scrub_we;

   rf_scrub_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scrub (
      .clock          (clock),
      .reset          (reset),
      .clear_i        (clear_ip),
      .scrub_active_o (scrub_active),
      .scrub_addr_o   (scrub_addr),
      .scrub_we_o     (scrub_we)
   );

   assign clear_busy_op = scrub_active;

   // Next-state of storage and scoreboard: scrub overrides all traffic;
   // otherwise later write ports override earlier ones and reserve wins last.
   always_comb begin
      rf_d   = rf_q;
      busy_d = busy_q;
      if (scrub_active) begin
         if (scrub_we) begin
            rf_d[scrub_addr]   = '0;
            busy_d[scrub_addr] = 1'b0;
         end
      end else begin
         for (int j = 0; j < NUM_WRITE; j++) begin
            if (we_ip[j] && (waddr_ip[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
               rf_d[waddr_ip[j*ADDR_WIDTH +: ADDR_WIDTH]]   = wdata_ip[j*DATA_WIDTH +: DATA_WIDTH];
               busy_d[waddr_ip[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
         end
         if (reserve_ip && (reserve_addr_ip != '0)) begin
            busy_d[reserve_addr_ip] = 1'b1;
         end
      end
   end

   // Storage and scoreboard registers, fully cleared by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            rf_q[w] <= '0;
         end
         busy_q <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports with optional same-cycle write forwarding.
   always_comb begin
      rdata_op = '0;
      rbusy_op = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         rdata_op[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr_ip[i*ADDR_WIDTH +: ADDR_WIDTH]];
         rbusy_op[i] = busy_q[raddr_ip[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef RF_BYPASS_EN
         if (!scrub_active) begin
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (we_ip[j] &&
                   (waddr_ip[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr_ip[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                  rdata_op[i*DATA_WIDTH +: DATA_WIDTH] = wdata_ip[j*DATA_WIDTH +: DATA_WIDTH];
                  rbusy_op[i] = reserve_ip &&
                                (reserve_addr_ip == raddr_ip[i*ADDR_WIDTH +: ADDR_WIDTH]);
               end
            end
         end
`endif
         // Register 0 is constant zero regardless of storage or forwarding.
         if (raddr_ip[i*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
            rdata_op[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            rbusy_op[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file (default geometry).
module tb_multiport_register_file;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int NWORDS = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic [NR*AW-1:0] raddr_ip;
   logic [NR*DW-1:0] rdata_op;
   logic [NR-1:0]    rbusy_op;
   logic [NW*AW-1:0] waddr_ip;
   logic [NW*DW-1:0] wdata_ip;
   logic [NW-1:0]    we_ip;
   logic             reserve_ip;
   logic [AW-1:0]    reserve_addr_ip;
   logic             clear_ip;
   logic             clear_busy_op;

   always #5 clock = ~clock;

   multiport_register_file #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_READ   (NR),
      .NUM_WRITE  (NW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .raddr_ip        (raddr_ip),
      .rdata_op        (rdata_op),
      .rbusy_op        (rbusy_op),
      .waddr_ip        (waddr_ip),
      .wdata_ip        (wdata_ip),
      .we_ip           (we_ip),
      .reserve_ip      (reserve_ip),
      .reserve_addr_ip (reserve_addr_ip),
      .clear_ip        (clear_ip),
      .clear_busy_op   (clear_busy_op)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: architectural contents plus scrub progress.
   logic [31:0] m_rf [NWORDS];
   bit          m_busy [NWORDS];
   int          scrub_left;
   int          scrub_pos;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        rsv;
      logic [4:0]  ra;
      logic [31:0] exp_d;
      logic        exp_b;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we_ip = '0;
      waddr_ip = '0;
      wdata_ip = '0;
      reserve_ip = 1'b0;
      reserve_addr_ip = '0;
      clear_ip = 1'b0;
   endtask

   task automatic set_write(input int p, input logic [4:0] a, input logic [31:0] d);
      we_ip[p] = 1'b1;
      waddr_ip[p*AW +: AW] = a;
      wdata_ip[p*DW +: DW] = d;
   endtask

   task automatic set_raddr(input int p, input logic [4:0] a);
      raddr_ip[p*AW +: AW] = a;
   endtask

   task automatic model_reset();
      for (int k = 0; k < NWORDS; k++) begin
         m_rf[k] = '0;
         m_busy[k] = 1'b0;
      end
      scrub_left = 0;
      scrub_pos = 0;
   endtask

   task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
      d = m_rf[a];
      b = m_busy[a];
`ifdef RF_BYPASS_EN
      if (scrub_left == 0) begin
         for (int j = 0; j < NW; j++) begin
            if (we_ip[j] && waddr_ip[j*AW +: AW] == a) begin
               d = wdata_ip[j*DW +: DW];
               b = reserve_ip && (reserve_addr_ip == a);
            end
         end
      end
`endif
      if (a == 5'd0) begin
         d = '0;
         b = 1'b0;
      end
   endtask

   // Apply one clock edge to the model using the inputs now driven, then
   // let the DUT take the same edge.
   task automatic tick();
      if (scrub_left > 0) begin
         m_rf[scrub_pos] = '0;
         m_busy[scrub_pos] = 1'b0;
         scrub_pos++;
         scrub_left--;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (we_ip[j] && waddr_ip[j*AW +: AW] != 5'd0) begin
               m_rf[waddr_ip[j*AW +: AW]] = wdata_ip[j*DW +: DW];
               m_busy[waddr_ip[j*AW +: AW]] = 1'b0;
            end
         end
         if (reserve_ip && reserve_addr_ip != 5'd0) m_busy[reserve_addr_ip] = 1'b1;
         if (clear_ip) begin
            scrub_left = NWORDS - 1;
            scrub_pos = 1;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic check_ports(input string tag);
      logic [31:0] ed;
      logic        eb;
      #1;
      for (int i = 0; i < NR; i++) begin
         model_read(raddr_ip[i*AW +: AW], ed, eb);
         chk($sformatf("%s_rdata%0d_a%0d", tag, i, raddr_ip[i*AW +: AW]), rdata_op[i*DW +: DW], ed);
         chk($sformatf("%s_rbusy%0d_a%0d", tag, i, raddr_ip[i*AW +: AW]), {31'd0, rbusy_op[i]}, {31'd0, eb});
      end
      chk({tag, "_clear_busy"}, {31'd0, clear_busy_op}, {31'd0, (scrub_left > 0)});
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < NWORDS; a++) begin
         set_raddr(0, 5'(a));
         set_raddr(1, 5'(NWORDS - 1 - a));
         #1;
         chk($sformatf("%s_zero_a%0d", tag, a), rdata_op[0 +: DW], 32'd0);
         chk($sformatf("%s_nobusy_a%0d", tag, a), {30'd0, rbusy_op}, 32'd0);
         check_ports(tag);
      end
   endtask

   task automatic fill_all();
      for (int k = 1; k < NWORDS; k += 2) begin
         idle_inputs();
         set_write(0, 5'(k), 32'h0101_0101 * k ^ 32'h5A5A_0000);
         if (k + 1 < NWORDS) set_write(1, 5'(k + 1), 32'h0101_0101 * (k + 1) ^ 32'h5A5A_0000);
         tick();
      end
      idle_inputs();
      reserve_ip = 1'b1;
      reserve_addr_ip = 5'd20;
      tick();
      idle_inputs();
   endtask

   initial begin
      int n;
      reset = 1'b1;
      raddr_ip = '0;
      idle_inputs();
      model_reset();
      #12;
      reset = 1'b0;

      // Reset state on every address.
      check_all_zero("reset");

      // Directed vectors.
      vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
      vt[1]  = '{2'b01, 5'd0, 32'h00001234, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
      vt[2]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd7, 32'h22, 1'b0};
      vt[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0, 1'b1};
      vt[4]  = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0, 5'd9, 32'h99, 1'b0};
      vt[5]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'hAB, 1'b1, 5'd9, 32'hAB, 1'b1};
      vt[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAB, 1'b1};
      vt[7]  = '{2'b11, 5'd9, 32'h1, 5'd9, 32'h3, 1'b0, 5'd9, 32'h3, 1'b0};
      vt[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 1'b0};
      vt[9]  = '{2'b11, 5'd12, 32'hAAAA, 5'd13, 32'hBBBB, 1'b0, 5'd13, 32'hBBBB, 1'b0};
      vt[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};

      for (int v = 0; v < 11; v++) begin
         idle_inputs();
         we_ip = vt[v].we;
         waddr_ip = {vt[v].a1, vt[v].a0};
         wdata_ip = {vt[v].d1, vt[v].d0};
         reserve_ip = vt[v].rsv;
         reserve_addr_ip = vt[v].ra;
         tick();
         idle_inputs();
         set_raddr(0, vt[v].ra);
         set_raddr(1, vt[v].ra);
         #1;
         chk($sformatf("vec%0d_rdata", v), rdata_op[0 +: DW], vt[v].exp_d);
         chk($sformatf("vec%0d_rbusy", v), {31'd0, rbusy_op[1]}, {31'd0, vt[v].exp_b});
         check_ports($sformatf("vec%0d", v));
      end

      // Same-cycle write/read of addr 3: forwarded only with the bypass build.
      idle_inputs();
      set_write(0, 5'd3, 32'hA5);
      set_raddr(0, 5'd3);
      set_raddr(1, 5'd3);
      #1;
`ifdef RF_BYPASS_EN
      chk("bypass_a3", rdata_op[0 +: DW], 32'hA5);
`else
      chk("nobypass_a3", rdata_op[0 +: DW], 32'h0);
`endif
      check_ports("samecyc");
      tick();
      idle_inputs();
      check_ports("after_a3");
      chk("a3_committed", rdata_op[DW +: DW], 32'hA5);

      // Full scrub with a write alongside the clear and traffic injected mid-scrub.
      fill_all();
      for (int a = 0; a < NWORDS; a++) begin
         set_raddr(0, 5'(a));
         set_raddr(1, 5'((a * 7) % NWORDS));
         check_ports("filled");
      end
      idle_inputs();
      clear_ip = 1'b1;
      set_write(1, 5'd4, 32'h00C0FFEE);
      tick();
      idle_inputs();
      set_raddr(0, 5'd4);
      #1;
      chk("write_at_clear", rdata_op[0 +: DW], 32'h00C0FFEE);
      n = 0;
      while (clear_busy_op === 1'b1 && n < 40) begin
         n++;
         set_raddr(0, 5'(scrub_pos));
         set_raddr(1, 5'($urandom_range(0, NWORDS - 1)));
         if (n == 6) begin
            set_write(0, 5'd30, 32'h0BAD0BAD);
            set_write(1, 5'd2, 32'h0BAD0002);
            reserve_ip = 1'b1;
            reserve_addr_ip = 5'd31;
            clear_ip = 1'b1;
         end
         check_ports("scrub");
         tick();
         idle_inputs();
      end
      chk("scrub_len", n, 32'd31);
      check_all_zero("scrubbed");

      // Reset asserted mid-scrub with the counter at 12.
      fill_all();
      clear_ip = 1'b1;
      tick();
      idle_inputs();
      for (int k = 0; k < 11; k++) tick();
      set_raddr(0, 5'd12);
      set_raddr(1, 5'd25);
      check_ports("pre_reset");
      chk("pre_reset_active", {31'd0, clear_busy_op}, 32'd1);
      reset = 1'b1;
      #1;
      chk("reset_mid_scrub", {31'd0, clear_busy_op}, 32'd0);
      model_reset();
      check_all_zero("midreset");
      #3;
      reset = 1'b0;
      tick();
      check_ports("post_reset");

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         idle_inputs();
         for (int j = 0; j < NW; j++) begin
            if ($urandom_range(0, 2) != 0)
               set_write(j, 5'($urandom_range(0, NWORDS - 1)), $urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            reserve_ip = 1'b1;
            reserve_addr_ip = 5'($urandom_range(0, NWORDS - 1));
         end
         if ($urandom_range(0, 59) == 0) clear_ip = 1'b1;
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 2) == 0 && we_ip[0])
               set_raddr(i, waddr_ip[0 +: AW]);
            else
               set_raddr(i, 5'($urandom_range(0, NWORDS - 1)));
         end
         check_ports("rand");
         tick();
      end
      idle_inputs();
      check_ports("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
